chan_count_tx: RTL and testbench
================================

# chan_count_tx

Multi-channel gated event counter with snapshot capture and framed serial readout. It is the parametrised successor to the single-channel counter, snapshot buffer and serial shifter chain in the top level. NCH independent counters run in the fast counting domain. A latch strobe captures all of them atomically into shadow registers, and a built-in serializer sends a header plus all channel words MSB-first with its own bit clock. It sits between the clock-divider chain, which supplies the latch strobe, and the output pins (serout, clktap, done flag).

## Interface
- WIDTH, 30, bits per channel counter and per transmitted channel word
- NCH, 2, number of counter channels (1..8)
- BIT_DIV, 50000, clk cycles per serial bit; even, >= 4
- CLEAR_ON_LATCH, 1, 1: counters clear on an accepted latch; 0: counters free-run
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; clears all state on the next clk edge
- ena  in  NCH  per-channel count inputs, synchronous to clk
- mode  in  1  0: count cycles with ena[i]=1 (gated time); 1: count rising edges of ena[i]
- latch  in  1  single-cycle capture/transmit request
- sout  out  1  serial data, idle 0
- bclk  out  1  bit clock, idle 0; receiver samples sout on bclk rising edge
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame
- overrun  out  1  sticky: a latch was rejected since the last accepted latch

## Operation
- Counters
  - Each channel has a WIDTH-bit counter. It wraps modulo 2^WIDTH with no saturation.
  - mode=0: increment on every cycle where ena[i]=1.
  - mode=1: increment when ena[i]=1 and prev[i]=0. prev[i] is a per-channel register.
  - During reset, prev[i] loads ena[i], so an input already high at reset release is not counted.
  - mode is applied combinationally each cycle. Change it only while busy=0.
- Accepted latch: latch=1 and busy=0 (the done cycle counts as busy=0).
  - Shadow[i] takes the counter value before that cycle's increment.
  - The overrun flag is copied into header bit HDR_OVR, and then overrun clears.
  - If CLEAR_ON_LATCH=1, counter[i] takes the increment of that cycle only: 1 if counting, else 0.
  - Entering SEND sets busy=1.
- Rejected latch: latch=1 while busy=1.
  - No snapshot and no counter clear.
  - overrun is set to 1.
- Frame layout: FRAME_BITS = 5 + NCH*WIDTH bits.
  - First the sync pattern 4'b1010, MSB first.
  - Then HDR_OVR.
  - Then shadow[NCH-1] down to shadow[0], each MSB-first.
- State machine with states IDLE and SEND.
  - IDLE -> SEND on an accepted latch.
  - SEND -> IDLE after the last bit period of the frame completes.
  - Any state -> IDLE on reset, with done and bclk forced low.

## Timing
- Reset values:
  - sout=0, bclk=0, busy=0, done=0, overrun=0.
  - All counters, shadows, bit counter and phase counter are 0.
- Latency: latch sampled at edge N gives busy=1 and sout = first sync bit (1) after edge N. Shadows are valid after edge N.
- Each bit holds for BIT_DIV cycles:
  - bclk=0 for the first BIT_DIV/2 cycles, then bclk=1 for the second half.
  - sout changes only on the cycle bclk falls, or at frame start.
- End of frame, at FRAME_BITS*BIT_DIV cycles after edge N:
  - busy=0, done=1 for one cycle, sout=0, bclk=0.
- A latch coincident with done is accepted, giving back-to-back frames with no idle cycle.
- A reset during SEND aborts the frame immediately with no done pulse. It also clears overrun.

## Structure
- Shared package: SYNC_PATTERN (4'b1010), HDR_BITS (5), state encoding (IDLE, SEND), and the function frame_bits(NCH, WIDTH).
- Sub-module chan_counter: one per channel, holding the counter, the edge-detect register and the shadow. Its inputs are clk, reset, ena, mode, capture and clear; its output is shadow. It is instantiated with a generate loop.
- The top of chan_count_tx holds the FSM, the phase and bit counters, and the frame mux.

## Test plan
Test parameters: WIDTH=8, NCH=2, BIT_DIV=4.
- Reset: after reset, all outputs are 0. With ena=2'b11 high through reset and mode=1, then latch, both channel words are 0x00.
- Gated count: mode=0, ena[0] high 37 cycles, ena[1] high 5 cycles, then latch. Frame is 1010 0, then 0x05, then 0x25. Frame is 21 bits, busy lasts 84 cycles, and done pulses once.
- Edge count: mode=1, 3 pulses on ena[1] and 200 pulses on ena[0], then latch. Words are 0x03 and 0xC8. A second latch after done sends 0x00 and 0x00 (CLEAR_ON_LATCH=1).
- Wrap and free-run: CLEAR_ON_LATCH=0, ena[0] high 300 cycles, two latches 100 cycles apart. First word is 0x2C; after a further 100 counts the second word is 0x90.
- Overrun and back-to-back: a latch mid-frame sets overrun=1 and leaves the frame unchanged. A latch on the done cycle is accepted, and its frame has HDR_OVR=1. overrun then reads 0.
- Reset mid-frame: assert reset at bit 7. Next cycle: busy=0, sout=0, bclk=0, and no done pulse follows.

Source files
------------

// File: rtl/chan_count_tx_pkg.sv
// Shared constants, state encoding and frame-length helper for chan_count_tx.
package chan_count_tx_pkg;

  // Sync pattern that opens every frame, sent MSB first.
  localparam logic [3:0] SYNC_PATTERN = 4'b1010;

  // Sync pattern plus the overrun header bit.
  localparam int HDR_BITS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Total serial bits in one frame: header followed by one word per channel.
  function automatic int frame_bits(input int nch, input int width);
    return HDR_BITS + nch * width;
  endfunction

endpackage

// File: rtl/chan_count_tx_counter.sv
// One counting channel: wrap-around event counter, edge-detect register and
// the shadow word captured on an accepted latch.
module chan_counter #(
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             mode,
  input  logic             capture,
  input  logic             clear,
  output logic [WIDTH-1:0] shadow
);

  logic             prev;
  logic [WIDTH-1:0] count;
  logic             inc;

  // mode=0 counts enabled cycles, mode=1 counts rising edges of ena.
  assign inc = mode ? (ena & ~prev) : ena;

  // Counter, edge history and snapshot; prev tracks ena even in reset so a
  // level already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      count  <= '0;
      prev   <= ena;
      // NOTE: shadow is a handful of flops, not a memory array, so it is
      // cleared here like any other state register.
      shadow <= '0;
    end else begin
      prev <= ena;
      if (capture) shadow <= count;
      if (clear) count <= WIDTH'(inc);
      else       count <= count + WIDTH'(inc);
    end
  end

endmodule

// File: rtl/chan_count_tx.sv
// Multi-channel gated event counter with atomic snapshot and framed,
// self-clocked MSB-first serial readout.
module chan_count_tx
  import chan_count_tx_pkg::*;
#(
  parameter int WIDTH          = 30,
  parameter int NCH            = 2,
  parameter int BIT_DIV        = 50000,
  parameter bit CLEAR_ON_LATCH = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] ena,
  input  logic           mode,
  input  logic           latch,
  output logic           sout,
  output logic           bclk,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  localparam int FRAME_BITS = frame_bits(NCH, WIDTH);
  localparam int PH_W       = $clog2(BIT_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BIT_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  state_t             state, state_d;
  logic [PH_W-1:0]    phase, phase_d;
  logic [BIT_W-1:0]   bit_cnt, bit_d;
  logic               done_d, sout_d, bclk_d;
  logic               hdr_ovr;
  logic               accept, clear;
  logic [NCH*WIDTH-1:0] shadow_flat;
  logic [FRAME_BITS-1:0] frame;

  // The done cycle is already IDLE, so a latch there starts the next frame.
  assign accept = latch && (state == IDLE);
  assign clear  = accept && CLEAR_ON_LATCH;
  assign busy   = (state == SEND);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    chan_counter #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .ena     (ena[i]),
      .mode    (mode),
      .capture (accept),
      .clear   (clear),
      .shadow  (shadow_flat[i*WIDTH +: WIDTH])
    );
  end

  // Highest channel sits in the upper bits, so MSB-first order falls out.
  assign frame = {SYNC_PATTERN, hdr_ovr, shadow_flat};

  // Next-state, bit timing and the next values of the registered pins.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state;
    phase_d = phase;
    bit_d   = bit_cnt;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (latch) begin
          state_d = SEND;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      SEND: begin
        if (phase == PH_LAST) begin
          phase_d = '0;
          if (bit_cnt == BIT_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end else begin
          phase_d = phase + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bits advance only when the phase wraps, which is also where bclk falls.
    sout_d = (state_d == SEND) && frame[BIT_LAST - bit_d];
    bclk_d = (state_d == SEND) && (phase_d >= PH_HALF);
  end

  // FSM, timing counters and glitch-free registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
      sout    <= 1'b0;
      bclk    <= 1'b0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      bit_cnt <= bit_d;
      done    <= done_d;
      sout    <= sout_d;
      bclk    <= bclk_d;
    end
  end

  // Sticky overrun: set by a latch refused mid-frame, handed to the header
  // and cleared by the next accepted latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      hdr_ovr <= 1'b0;
    end else if (accept) begin
      hdr_ovr <= overrun;
      overrun <= 1'b0;
    end else if (latch) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chan_count_tx.sv
// Self-checking bench for chan_count_tx: directed scenarios plus random
// enables, with a cycle-level behavioural model of counts and framing.
module tb_chan_count_tx;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int BD = 4;
  localparam int FB = 5 + N * W;
  localparam int FRAME_CYC = FB * BD;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] ena = '0;
  logic         mode = 1'b0;
  logic         latch = 1'b0;

  // c: counters clear on latch, f: free-running counters.
  logic sout_c, bclk_c, busy_c, done_c, ovr_c;
  logic sout_f, bclk_f, busy_f, done_f, ovr_f;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  chan_count_tx #(.WIDTH(W), .NCH(N), .BIT_DIV(BD), .CLEAR_ON_LATCH(1'b1)) dut_c (
    .clk(clk), .reset(reset), .ena(ena), .mode(mode), .latch(latch),
    .sout(sout_c), .bclk(bclk_c), .busy(busy_c), .done(done_c), .overrun(ovr_c)
  );

  chan_count_tx #(.WIDTH(W), .NCH(N), .BIT_DIV(BD), .CLEAR_ON_LATCH(1'b0)) dut_f (
    .clk(clk), .reset(reset), .ena(ena), .mode(mode), .latch(latch),
    .sout(sout_f), .bclk(bclk_f), .busy(busy_f), .done(done_f), .overrun(ovr_f)
  );

  always #5 clk = ~clk;

  // Reference model state. Index 0 models dut_c, index 1 models dut_f.
  logic [W-1:0]  mcnt [2][N];
  logic [N-1:0]  mprev = '0;
  logic [FB-1:0] cur [2];
  int            left = 0;
  bit            movr = 1'b0;
  bit            mdone = 1'b0;
  bit            rand_ena = 1'b0;

  // Frames as reassembled from sout on each bclk rising edge.
  logic [FB-1:0] rx_c = '0, rx_f = '0;
  logic          pb_c = 1'b0, pb_f = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] make_frame(input bit ovr, input logic [W-1:0] w1,
                                               input logic [W-1:0] w0);
    return {4'b1010, ovr, w1, w0};
  endfunction

  // One clock: update the model from the inputs seen at the edge, then
  // compare every output of both DUTs and run the serial receivers.
  task automatic tick();
    bit acc, rej, bsy, ebclk, esout;
    bit inc [N];
    int pos;
    if (rand_ena) ena = N'($urandom);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) mcnt[k][i] = '0;
      mprev = ena;
      left  = 0;
      movr  = 1'b0;
      mdone = 1'b0;
    end else begin
      bsy = (left > 0);
      acc = latch && !bsy;
      rej = latch && bsy;
      for (int i = 0; i < N; i++) inc[i] = mode ? (ena[i] && !mprev[i]) : ena[i];
      if (acc) begin
        for (int k = 0; k < 2; k++) cur[k] = make_frame(movr, mcnt[k][1], mcnt[k][0]);
        movr  = 1'b0;
        left  = FRAME_CYC;
        mdone = 1'b0;
      end else begin
        mdone = (left == 1);
        if (left > 0) left--;
        if (rej) movr = 1'b1;
      end
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++)
          if (acc && k == 0) mcnt[k][i] = W'(inc[i]);
          else               mcnt[k][i] = mcnt[k][i] + W'(inc[i]);
      mprev = ena;
    end
    #1;
    cyc++;
    pos = FRAME_CYC - left;
    for (int k = 0; k < 2; k++) begin
      ebclk = (left > 0) && ((pos % BD) >= BD / 2);
      esout = (left > 0) && cur[k][FB-1-pos/BD];
      check($sformatf("busy%0d@%0d", k, cyc), (k == 0) ? busy_c : busy_f, left > 0);
      check($sformatf("done%0d@%0d", k, cyc), (k == 0) ? done_c : done_f, mdone);
      check($sformatf("ovr%0d@%0d", k, cyc), (k == 0) ? ovr_c : ovr_f, movr);
      check($sformatf("bclk%0d@%0d", k, cyc), (k == 0) ? bclk_c : bclk_f, ebclk);
      check($sformatf("sout%0d@%0d", k, cyc), (k == 0) ? sout_c : sout_f, esout);
    end
    if (bclk_c && !pb_c) rx_c = {rx_c[FB-2:0], sout_c};
    if (bclk_f && !pb_f) rx_f = {rx_f[FB-2:0], sout_f};
    pb_c = bclk_c;
    pb_f = bclk_f;
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    tick();
    latch = 1'b0;
  endtask

  // Bounded wait for the end-of-frame pulse; a timeout counts as a failure.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_c && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_c, 1'b1);
  endtask

  initial begin
    int nb, nd;
    logic [FB-1:0] saved;
    for (int k = 0; k < 2; k++) begin
      cur[k] = '0;
      for (int i = 0; i < N; i++) mcnt[k][i] = '0;
    end

    // Reset with both enables high in edge mode.
    reset = 1'b1; ena = 2'b11; mode = 1'b1;
    repeat (3) tick();
    check("rst_sout", sout_c, 1'b0);
    check("rst_bclk", bclk_c, 1'b0);
    check("rst_busy", busy_c, 1'b0);
    check("rst_done", done_c, 1'b0);
    check("rst_ovr",  ovr_c,  1'b0);
    reset = 1'b0;
    repeat (2) tick();
    pulse_latch();
    wait_done("rst");
    check("rst_frame", rx_c, make_frame(1'b0, 8'h00, 8'h00));
    ena = '0;
    repeat (3) tick();

    // Gated count: 37 cycles on ch0, 5 on ch1.
    mode = 1'b0;
    ena = 2'b11; repeat (5) tick();
    ena = 2'b01; repeat (32) tick();
    ena = 2'b00;
    pulse_latch();
    nb = 0; nd = 0;
    for (int i = 0; i < FRAME_CYC + 8; i++) begin
      if (busy_c) nb++;
      if (done_c) nd++;
      tick();
    end
    check("gate_frame", rx_c, make_frame(1'b0, 8'h05, 8'h25));
    check("gate_busy_len", nb, FRAME_CYC);
    check("gate_done_cnt", nd, 1);

    // Edge count: 3 pulses on ch1, 200 on ch0; then a second latch.
    mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ena = {(i < 3), 1'b1};
      tick();
      ena = 2'b00;
      tick();
    end
    pulse_latch();
    wait_done("edge1");
    check("edge_frame1", rx_c, make_frame(1'b0, 8'h03, 8'hC8));
    tick();
    pulse_latch();
    wait_done("edge2");
    check("edge_frame2", rx_c, make_frame(1'b0, 8'h00, 8'h00));

    // Wrap and free-run: latches 100 cycles apart with ch0 always enabled.
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b0; ena = 2'b01;
    repeat (300) tick();
    pulse_latch();
    repeat (99) tick();
    check("wrap_f1", rx_f, make_frame(1'b0, 8'h00, 8'h2C));
    check("wrap_c1", rx_c, make_frame(1'b0, 8'h00, 8'h2C));
    pulse_latch();
    ena = 2'b00;
    wait_done("wrap2");
    check("wrap_f2", rx_f, make_frame(1'b0, 8'h00, 8'h90));
    check("wrap_c2", rx_c, make_frame(1'b0, 8'h00, 8'h64));
    tick();

    // Overrun and back-to-back, with random enables.
    rand_ena = 1'b1;
    pulse_latch();
    saved = cur[0];
    repeat (30) tick();
    pulse_latch();
    check("ovr_set", ovr_c, 1'b1);
    wait_done("ovr1");
    check("ovr_frame_kept", rx_c, saved);
    pulse_latch();
    check("b2b_busy", busy_c, 1'b1);
    check("b2b_ovr_clr", ovr_c, 1'b0);
    wait_done("b2b");
    check("b2b_hdr_ovr", rx_c[FB-5], 1'b1);
    rand_ena = 1'b0;
    tick();

    // Reset during bit 7 aborts without done.
    pulse_latch();
    repeat (7 * BD) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy_c, 1'b0);
    check("abort_sout", sout_c, 1'b0);
    check("abort_bclk", bclk_c, 1'b0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      tick();
      if (done_c) nd++;
    end
    check("abort_no_done", nd, 0);

    // Random soak: random enables, occasional latches, both modes.
    rand_ena = 1'b1;
    for (int s = 0; s < 2; s++) begin
      mode = s[0];
      for (int i = 0; i < 600; i++) begin
        latch = ($urandom_range(0, 39) == 0);
        tick();
      end
      latch = 1'b0;
      repeat (FRAME_CYC + 2) tick();
    end
    rand_ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
